// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage with the IF/ID boundary, sitting directly upstream
// of the control unit. It owns the program counter, drives a synchronous
// instruction memory with one cycle of read latency, and presents the
// fetched instruction plus its decoded tipo/op/Inm fields. Stalls and
// redirects that are resolved further down the pipe are applied here.
//
// Ports:
//   clk              clock, every state update happens on the rising edge
//   rst              synchronous active-high reset
//   stall            hold the PC and the ID contents
//   redirect         taken branch / jump / return this cycle
//   pc_direction     with redirect: 1 = return_addr, 0 = redirect_target
//   redirect_target  branch or jump target
//   return_addr      return address
//   imem_addr        instruction memory read address (address issued now)
//   imem_rdata       instruction for the address issued the previous cycle
//   id_valid         ID slot holds a real instruction
//   id_instr         instruction in ID, zero when id_valid is low
//   id_pc            address of id_instr
//   id_pc_plus1      id_pc + 1 with wrap, used as the return-link value
//   tipo, op, Inm    decoded fields of id_instr, zero when id_valid is low
// ---------------------------------------------------------------------------
module fetch_stage #(
   parameter int              PC_W     = 9,
   parameter int              INSTR_W  = 24,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               redirect,
   input  logic               pc_direction,
   input  logic [PC_W-1:0]    redirect_target,
   input  logic [PC_W-1:0]    return_addr,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               id_valid,
   output logic [INSTR_W-1:0] id_instr,
   output logic [PC_W-1:0]    id_pc,
   output logic [PC_W-1:0]    id_pc_plus1,
   output logic [1:0]         tipo,
   output logic [1:0]         op,
   output logic               Inm
);

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HOLD   = 2'd2,
      BUBBLE = 2'd3
   } fetch_state_t;

   fetch_state_t        state;
   logic [PC_W-1:0]     pc_q;
   logic [PC_W-1:0]     f_pc_q;
   logic [INSTR_W-1:0]  hold_instr_q;

   // PC and IF/ID state update. Priority is reset, then redirect, then
   // stall, then normal sequential fetch.
   // During a stall the memory keeps re-reading pc_q, so on the next edge
   // imem_rdata would already show the *following* instruction. The
   // instruction currently in ID is therefore captured into hold_instr_q on
   // the first stalled edge, and shown from there until the stall releases.
   // On release the memory returns the instruction at the old pc_q, which is
   // exactly the successor of the held one, so nothing is skipped or repeated.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q         <= RESET_PC;
         f_pc_q       <= RESET_PC;
         hold_instr_q <= '0;
         state        <= BOOT;
      end else if (redirect) begin
         // The instruction read this cycle belongs to the wrong path, so the
         // next cycle is a bubble; any held instruction is simply abandoned.
         pc_q   <= pc_direction ? return_addr : redirect_target;
         f_pc_q <= pc_q;
         state  <= BUBBLE;
      end else if (stall) begin
         if (state == RUN) begin
            hold_instr_q <= imem_rdata;
            state        <= HOLD;
         end
      end else begin
         pc_q   <= pc_q + 1'b1;
         f_pc_q <= pc_q;
         state  <= RUN;
      end
   end

   // ID instruction source selected by state; BOOT and BUBBLE present a
   // zero instruction so the control unit sees all-zero fields.
   always_comb begin
      id_instr = '0;
      id_valid = 1'b0;
      case (state)
         RUN: begin
            id_instr = imem_rdata;
            id_valid = 1'b1;
         end
         HOLD: begin
            id_instr = hold_instr_q;
            id_valid = 1'b1;
         end
         default: begin
            id_instr = '0;
            id_valid = 1'b0;
         end
      endcase
   end

   assign imem_addr   = pc_q;
   assign id_pc       = f_pc_q;
   assign id_pc_plus1 = f_pc_q + 1'b1;

   assign tipo = id_instr[INSTR_W-1:INSTR_W-2];
   assign op   = id_instr[INSTR_W-3:INSTR_W-4];
   assign Inm  = id_instr[INSTR_W-5];

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed scoreboard bench for fetch_stage. A behavioural synchronous
// instruction memory feeds the DUT. Each stimulus cycle pushes the
// hand-derived expected ID contents (valid flag and id_pc) into a queue;
// a monitor on the falling edge pops entries and compares every ID output,
// deriving the expected instruction from the bench's own memory image.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

   localparam int PC_W    = 9;
   localparam int INSTR_W = 24;

   logic               clk;
   logic               rst;
   logic               stall;
   logic               redirect;
   logic               pc_direction;
   logic [PC_W-1:0]    redirect_target;
   logic [PC_W-1:0]    return_addr;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic               id_valid;
   logic [INSTR_W-1:0] id_instr;
   logic [PC_W-1:0]    id_pc;
   logic [PC_W-1:0]    id_pc_plus1;
   logic [1:0]         tipo;
   logic [1:0]         op;
   logic               Inm;

   typedef struct {
      logic            valid;
      logic [PC_W-1:0] pc;
   } exp_t;

   exp_t               sbq[$];
   logic [INSTR_W-1:0] imem [512];
   int                 checks   = 0;
   int                 failures = 0;

   fetch_stage #(
      .PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC('0)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
      .pc_direction(pc_direction), .redirect_target(redirect_target),
      .return_addr(return_addr), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .id_valid(id_valid), .id_instr(id_instr),
      .id_pc(id_pc), .id_pc_plus1(id_pc_plus1), .tipo(tipo), .op(op),
      .Inm(Inm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read memory with one cycle of latency.
   always @(posedge clk) imem_rdata <= imem[imem_addr];

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t",
                  name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs, let the edge happen, then queue the ID
   // contents expected to be visible during the following cycle.
   task automatic applyStimulus(input logic r, input logic s, input logic rd,
                                input logic dir, input logic [PC_W-1:0] tgt,
                                input logic [PC_W-1:0] ret,
                                input logic expValid,
                                input logic [PC_W-1:0] expPc);
      exp_t e;
      rst             = r;
      stall           = s;
      redirect        = rd;
      pc_direction    = dir;
      redirect_target = tgt;
      return_addr     = ret;
      @(posedge clk);
      #1;
      e.valid = expValid;
      e.pc    = expPc;
      sbq.push_back(e);
   endtask

   task automatic runNormal(input logic [PC_W-1:0] expPc);
      applyStimulus(0, 0, 0, 0, '0, '0, 1'b1, expPc);
   endtask

   // Monitor: compares every ID output against the popped expectation.
   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         exp_t               e;
         logic [INSTR_W-1:0] ei;
         logic [PC_W-1:0]    ep1;
         e   = sbq.pop_front();
         ei  = e.valid ? imem[e.pc] : '0;
         ep1 = e.pc + 1'b1;
         checkOutput("id_valid", 32'(id_valid), 32'(e.valid));
         checkOutput("id_instr", 32'(id_instr), 32'(ei));
         checkOutput("id_pc", 32'(id_pc), 32'(e.pc));
         checkOutput("id_pc_plus1", 32'(id_pc_plus1), 32'(ep1));
         checkOutput("tipo", 32'(tipo), 32'(ei[23:22]));
         checkOutput("op", 32'(op), 32'(ei[21:20]));
         checkOutput("Inm", 32'(Inm), 32'(ei[19]));
      end
   end

   initial begin
      for (int i = 0; i < 512; i++) imem[i] = 24'(i + 'h100);
      // A few locations with non-zero decode fields.
      imem[6]    = 24'hA00006;
      imem[9'h1F] = 24'h68001F;
      imem[9'h40] = 24'hD80040;
      imem[510]  = 24'h5801FE;

      rst = 1'b1; stall = 1'b0; redirect = 1'b0; pc_direction = 1'b0;
      redirect_target = '0; return_addr = '0;

      // Reset, then free-run from address 0.
      applyStimulus(1, 0, 0, 0, '0, '0, 1'b0, 9'd0);
      for (int i = 0; i <= 5; i++) runNormal(9'(i));

      // Stall three cycles while ID shows 5, then release.
      for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, '0, '0, 1'b1, 9'd5);
      for (int i = 6; i <= 10; i++) runNormal(9'(i));

      // Redirect to 0x40 while ID shows 10 (pc_q=11): one bubble.
      applyStimulus(0, 0, 1, 0, 9'h40, '0, 1'b0, 9'd11);
      runNormal(9'h40);
      runNormal(9'h41);

      // Return redirect together with stall: stall ignored.
      applyStimulus(0, 1, 1, 1, 9'h55, 9'h1F, 1'b0, 9'h42);
      runNormal(9'h1F);

      // Redirect to 510, stall during the bubble, then wrap.
      applyStimulus(0, 0, 1, 0, 9'd510, '0, 1'b0, 9'h20);
      applyStimulus(0, 1, 0, 0, '0, '0, 1'b0, 9'h20);
      runNormal(9'd510);
      runNormal(9'd511);
      runNormal(9'd0);
      runNormal(9'd1);

      // Reset asserted together with redirect and stall: reset wins.
      applyStimulus(1, 1, 1, 1, '0, 9'h1F, 1'b0, 9'd0);
      runNormal(9'd0);
      runNormal(9'd1);

      // Reset while holding, stall during BOOT.
      applyStimulus(0, 1, 0, 0, '0, '0, 1'b1, 9'd1);
      applyStimulus(1, 1, 0, 0, '0, '0, 1'b0, 9'd0);
      applyStimulus(0, 1, 0, 0, '0, '0, 1'b0, 9'd0);
      runNormal(9'd0);

      // Redirect out of HOLD (pc_q=1): held instruction dropped.
      applyStimulus(0, 1, 0, 0, '0, '0, 1'b1, 9'd0);
      applyStimulus(0, 1, 1, 0, 9'h40, '0, 1'b0, 9'd1);
      runNormal(9'h40);

      @(negedge clk);
      @(negedge clk);
      checks++;
      if (sbq.size() != 0) begin
         failures++;
         $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", sbq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      failures++;
      $display("[TB] FAIL timeout actual=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
